// File: rtl/ahb_dma_master.sv
// ahb_dma_master: single-channel AHB-Lite memory-copy master, one word per read/write pair.
// Optional word-fill mode (write-only jobs) is enabled by defining AHBDMA_FILL_EN.
module ahb_dma_master #(
    parameter int LEN_W = 12
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [3:0]       HPROT,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] count
`ifdef AHBDMA_FILL_EN
    ,
    input  logic             fill,
    input  logic [31:0]      fill_value
`endif
);
    localparam logic [2:0] IDLE = 3'd0, RD_A = 3'd1, RD_D = 3'd2, WR_A = 3'd3,
                           WR_D = 3'd4, DONE = 3'd5, ERR  = 3'd6;
    localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
`ifndef AHBDMA_FILL_EN
    logic        fill;
    logic [31:0] fill_value;
    assign fill       = 1'b0;
    assign fill_value = '0;
`endif
    logic [2:0]       state;
    logic [31:0]      src, dst, buf_q;
    logic [LEN_W-1:0] len, count_nx;
    logic             fill_q;
    assign HSIZE    = 3'b010;
    assign HPROT    = 4'b0011;
    assign count_nx = count + 1'b1;
    // Bus outputs are loaded on the same edge as the state change so every output is a flop.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state  <= IDLE;
            HADDR  <= '0;
            HTRANS <= T_IDLE;
            HWRITE <= 1'b0;
            HWDATA <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            count  <= '0;
            src    <= '0;
            dst    <= '0;
            buf_q  <= '0;
            len    <= '0;
            fill_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    error  <= 1'b0;
                    count  <= '0;
                    src    <= src_addr & WORD_MASK;
                    dst    <= dst_addr & WORD_MASK;
                    len    <= length;
                    fill_q <= fill;
                    buf_q  <= fill_value;
                    if (length == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state  <= fill ? WR_A : RD_A;
                        busy   <= 1'b1;
                        HADDR  <= (fill ? dst_addr : src_addr) & WORD_MASK;
                        HTRANS <= T_NONSEQ;
                        HWRITE <= fill;
                    end
                end
                RD_A: if (HREADY) begin
                    state  <= RD_D;
                    HTRANS <= T_IDLE;
                end
                RD_D: if (HRESP) begin
                    state <= ERR;
                    error <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else if (HREADY) begin
                    buf_q  <= HRDATA;
                    state  <= WR_A;
                    HADDR  <= dst;
                    HTRANS <= T_NONSEQ;
                    HWRITE <= 1'b1;
                end
                WR_A: if (HREADY) begin
                    state  <= WR_D;
                    HTRANS <= T_IDLE;
                    HWRITE <= 1'b0;
                    HWDATA <= buf_q;
                end
                WR_D: if (HRESP) begin
                    state <= ERR;
                    error <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else if (HREADY) begin
                    count <= count_nx;
                    src   <= src + 32'd4;
                    dst   <= dst + 32'd4;
                    if (count_nx == len) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state  <= fill_q ? WR_A : RD_A;
                        HADDR  <= fill_q ? dst + 32'd4 : src + 32'd4;
                        HTRANS <= T_NONSEQ;
                        HWRITE <= fill_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_dma_master.sv
// tb_ahb_dma_master: directed bench for ahb_dma_master with a wait-state/error-capable responder.
// Read data is the data-phase address XOR 0x5A5A0000, so written data reveals its source word.
module tb_ahb_dma_master;
    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0;
    logic [11:0] length = '0;
    logic        busy, done, error;
    logic [11:0] count;
`ifdef AHBDMA_FILL_EN
    logic        fill = 1'b0;
    logic [31:0] fill_value = '0;
`endif
    localparam logic [31:0] K = 32'h5A5A_0000;

    ahb_dma_master #(.LEN_W(12)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .length(length), .busy(busy), .done(done), .error(error), .count(count)
`ifdef AHBDMA_FILL_EN
        , .fill(fill), .fill_value(fill_value)
`endif
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0, c0 = 0, checks = 0, failures = 0;
    int ws = 0, err_idx = -1;
    int n_ph = 0, n_wr = 0, n_done = 0, viol = 0, dp_idx = 0, wcnt = 0;
    logic        dp_valid = 1'b0, dp_write = 1'b0, wd_seen = 1'b0, err_now;
    logic [31:0] dp_addr = '0, wd_prev = '0;
    logic [31:0] ph_addr [256];
    logic        ph_wr   [256];
    logic [31:0] w_addr  [256];
    logic [31:0] w_data  [256];

    assign err_now = dp_valid && dp_idx == err_idx;
    assign HREADY  = !dp_valid || (err_now ? wcnt == 1 : wcnt >= ws);
    assign HRESP   = err_now;
    assign HRDATA  = dp_addr ^ K;

    always @(posedge HCLK) begin
        cyc <= cyc + 1;
        if (done) n_done <= n_done + 1;
        if (wd_seen && HWDATA !== wd_prev) viol <= viol + 1;
        wd_seen <= dp_valid && dp_write && !HREADY;
        wd_prev <= HWDATA;
        if (HREADY) begin
            if (dp_valid && dp_write && !HRESP) begin
                w_addr[n_wr] <= dp_addr;
                w_data[n_wr] <= HWDATA;
                n_wr <= n_wr + 1;
            end
            wcnt     <= 0;
            dp_valid <= HTRANS == 2'b10;
            dp_write <= HWRITE;
            dp_addr  <= HADDR;
            dp_idx   <= n_ph;
            if (HTRANS == 2'b10) begin
                ph_addr[n_ph] <= HADDR;
                ph_wr[n_ph]   <= HWRITE;
                n_ph <= n_ph + 1;
            end
        end else wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [11:0] l);
        @(negedge HCLK);
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                lat = cyc - c0;
                break;
            end
            @(negedge HCLK);
        end
    endtask

    int lat, bp, bw, nd;

    initial begin
        repeat (3) @(negedge HCLK);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_htrans", {30'd0, HTRANS}, 32'h0);
        chk("rst_hwrite", {31'd0, HWRITE}, 32'h0);
        chk("rst_hsize", {29'd0, HSIZE}, 32'h2);
        chk("rst_hprot", {28'd0, HPROT}, 32'h3);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'h0);
        chk("rst_count", {20'd0, count}, 32'h0);
        HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);
        chk("post_rst_idle", n_ph, 0);

        // 3-word copy, zero wait states
        bp = n_ph; bw = n_wr;
        go(32'h2000_0000, 32'h2000_0100, 12'd3);
        chk("copy_busy", {31'd0, busy}, 32'h1);
        wait_done(lat);
        chk("copy_lat", lat, 12);
        chk("copy_busy_at_done", {31'd0, busy}, 32'h0);
        chk("copy_count", {20'd0, count}, 32'd3);
        @(negedge HCLK);
        chk("copy_done_1cyc", {31'd0, done}, 32'h0);
        chk("copy_nph", n_ph - bp, 6);
        chk("copy_a0", ph_addr[bp+0], 32'h2000_0000);
        chk("copy_a1", ph_addr[bp+1], 32'h2000_0100);
        chk("copy_a2", ph_addr[bp+2], 32'h2000_0004);
        chk("copy_a3", ph_addr[bp+3], 32'h2000_0104);
        chk("copy_a4", ph_addr[bp+4], 32'h2000_0008);
        chk("copy_a5", ph_addr[bp+5], 32'h2000_0108);
        chk("copy_rw", {26'd0, ph_wr[bp], ph_wr[bp+1], ph_wr[bp+2], ph_wr[bp+3], ph_wr[bp+4], ph_wr[bp+5]}, 32'b010101);
        chk("copy_w0", w_data[bw+0], 32'h2000_0000 ^ K);
        chk("copy_w1", w_data[bw+1], 32'h2000_0004 ^ K);
        chk("copy_w2", w_data[bw+2], 32'h2000_0008 ^ K);
        chk("copy_wa2", w_addr[bw+2], 32'h2000_0108);

        // same job, 2 wait states per data phase
        ws = 2; bp = n_ph; bw = n_wr;
        go(32'h2000_0000, 32'h2000_0100, 12'd3);
        wait_done(lat);
        chk("ws_lat", lat, 24);
        chk("ws_count", {20'd0, count}, 32'd3);
        chk("ws_nwr", n_wr - bw, 3);
        chk("ws_w1", w_data[bw+1], 32'h2000_0004 ^ K);
        chk("ws_hwdata_stable", viol, 0);
        ws = 0;

        // error in second read data phase
        repeat (2) @(negedge HCLK);
        bp = n_ph; bw = n_wr; nd = n_done; err_idx = n_ph + 2;
        go(32'h2000_0000, 32'h2000_0100, 12'd3);
        wait_done(lat);
        chk("err_lat", lat, 6);
        chk("err_flag", {31'd0, error}, 32'h1);
        chk("err_count", {20'd0, count}, 32'd1);
        repeat (4) @(negedge HCLK);
        err_idx = -1;
        chk("err_nph", n_ph - bp, 3);
        chk("err_nwr", n_wr - bw, 1);
        chk("err_done_once", n_done - nd, 1);
        chk("err_sticky", {31'd0, error}, 32'h1);

        // zero length clears error, no bus activity
        bp = n_ph;
        go(32'h2000_0000, 32'h2000_0100, 12'd0);
        chk("len0_err_clr", {31'd0, error}, 32'h0);
        chk("len0_busy", {31'd0, busy}, 32'h0);
        wait_done(lat);
        chk("len0_lat", lat, 0);
        repeat (3) @(negedge HCLK);
        chk("len0_nph", n_ph - bp, 0);
        chk("len0_htrans", {30'd0, HTRANS}, 32'h0);

        // start while busy and start coincident with done are both ignored
        bp = n_ph;
        go(32'h2000_0400, 32'h2000_0500, 12'd2);
        @(negedge HCLK);
        src_addr = 32'h3000_0000; length = 12'd5; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        wait_done(lat);
        chk("busy_lat", lat, 8);
        chk("busy_count", {20'd0, count}, 32'd2);
        src_addr = 32'h3000_0000; length = 12'd1; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        chk("done_start_busy", {31'd0, busy}, 32'h0);
        repeat (3) @(negedge HCLK);
        chk("busy_nph", n_ph - bp, 4);
        chk("busy_a2", ph_addr[bp+2], 32'h2000_0404);

        // source address wraps at 4 GiB
        bp = n_ph; bw = n_wr;
        go(32'hFFFF_FFFC, 32'h2000_0200, 12'd2);
        wait_done(lat);
        chk("wrap_lat", lat, 8);
        chk("wrap_a2", ph_addr[bp+2], 32'h0000_0000);
        chk("wrap_w1", w_data[bw+1], 32'h0000_0000 ^ K);
        chk("wrap_wa1", w_addr[bw+1], 32'h2000_0204);

`ifdef AHBDMA_FILL_EN
        bp = n_ph; bw = n_wr;
        fill = 1'b1; fill_value = 32'hA5A5_A5A5;
        go(32'h0, 32'h2000_0300, 12'd4);
        fill = 1'b0;
        wait_done(lat);
        chk("fill_lat", lat, 8);
        chk("fill_nph", n_ph - bp, 4);
        chk("fill_all_wr", {28'd0, ph_wr[bp], ph_wr[bp+1], ph_wr[bp+2], ph_wr[bp+3]}, 32'hF);
        chk("fill_w3", w_data[bw+3], 32'hA5A5_A5A5);
        chk("fill_wa3", w_addr[bw+3], 32'h2000_030C);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
